// File: rtl/hilo_unit.sv
// HI/LO register stage behind the ALU: captures 64-bit products and MTHI/MTLO
// writes, and runs DIV/DIVU as a multi-cycle restoring divider.
//
// state | meaning
// IDLE  | accepts Valid; WR64/MTHI/MTLO write HiLo directly
// ITER  | one restoring divide step per cycle, MSB first
// FIX   | sign-correct the result (or apply divide-by-zero value) into HiLo
module hilo_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Valid,
   input  logic [2:0]                Op,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   input  logic [2*DATA_WIDTH-1:0]   ALU64Result,
   output logic [2*DATA_WIDTH-1:0]   HiLo,
   output logic                      Busy,
   output logic                      Done,
   output logic                      DivByZero
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   localparam logic [2:0] OP_WR64 = 3'd1;
   localparam logic [2:0] OP_MTHI = 3'd2;
   localparam logic [2:0] OP_MTLO = 3'd3;
   localparam logic [2:0] OP_DIV  = 3'd4;
   localparam logic [2:0] OP_DIVU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   counter;
   logic [DW-1:0]   rem;
   logic [DW-1:0]   quot;
   logic [DW-1:0]   divisor;
   logic            qneg;
   logic            rneg;
   logic            dz;

   logic            accept;
   logic            start_div;
   logic            is_signed;
   logic [DW-1:0]   a_mag;
   logic [DW-1:0]   b_mag;
   logic [DW:0]     rem_sh;
   logic [DW:0]     diff;
   logic            ge;
   logic [DW-1:0]   rem_nxt;
   logic [DW-1:0]   quot_nxt;

   assign accept    = Valid && (state == S_IDLE);
   assign start_div = accept && ((Op == OP_DIV) || (Op == OP_DIVU));
   assign is_signed = (Op == OP_DIV);
   assign a_mag     = (is_signed && A[DW-1]) ? -A : A;
   assign b_mag     = (is_signed && B[DW-1]) ? -B : B;

   // Magnitudes are held as unsigned DW-bit values so 2^(DW-1) is representable.
   assign rem_sh   = {rem, quot[DW-1]};
   assign diff     = rem_sh - {1'b0, divisor};
   assign ge       = (rem_sh >= {1'b0, divisor});
   assign rem_nxt  = ge ? diff[DW-1:0] : rem_sh[DW-1:0];
   assign quot_nxt = {quot[DW-2:0], ge};

   assign Busy = (state != S_IDLE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start_div) begin
               state_nxt = (B == '0) ? S_FIX : S_ITER;
            end
         end
         S_ITER: begin
            if (counter == LAST) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         HiLo      <= '0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         counter   <= '0;
         rem       <= '0;
         quot      <= '0;
         divisor   <= '0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         dz        <= 1'b0;
      end else begin
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (Op)
                     OP_WR64: HiLo          <= ALU64Result;
                     OP_MTHI: HiLo[2*DW-1:DW] <= A;
                     OP_MTLO: HiLo[DW-1:0]  <= A;
                     default: ;
                  endcase
               end
               if (start_div) begin
                  // On divide-by-zero quot carries raw A through to HI.
                  dz      <= (B == '0);
                  quot    <= (B == '0) ? A : a_mag;
                  divisor <= b_mag;
                  rem     <= '0;
                  counter <= '0;
                  qneg    <= is_signed && (A[DW-1] ^ B[DW-1]);
                  rneg    <= is_signed && A[DW-1];
               end
            end
            S_ITER: begin
               rem     <= rem_nxt;
               quot    <= quot_nxt;
               counter <= counter + 1'b1;
            end
            S_FIX: begin
               if (dz) begin
                  HiLo      <= {quot, {DW{1'b1}}};
                  DivByZero <= 1'b1;
               end else begin
                  HiLo <= {(rneg ? -rem : rem), (qneg ? -quot : quot)};
               end
               Done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: driver pushes expected HiLo updates into a queue keyed by
// the cycle they should appear; a monitor pops and compares every cycle.
module tb_hilo_unit;

   typedef struct {
      int          cyc;
      logic [63:0] hilo;
      bit          is_div;
      bit          dbz;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Valid = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [63:0] ALU64Result = '0;
   logic [63:0] HiLo;
   logic        Busy;
   logic        Done;
   logic        DivByZero;

   hilo_unit #(.DATA_WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .Op(Op), .A(A), .B(B),
      .ALU64Result(ALU64Result), .HiLo(HiLo), .Busy(Busy), .Done(Done),
      .DivByZero(DivByZero)
   );

   always #5 Clk = ~Clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          bf = 1;
   int          bt = 0;
   logic [63:0] dm = '0;
   logic [63:0] mon = '0;
   exp_t        q[$];

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Reference divide: plain integer arithmetic on 64-bit values.
   function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q64, r64;
      logic [31:0] qu, ru;
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (op == 3'd5) begin
         qu = a / b;
         ru = a % b;
         return {ru, qu};
      end
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      return {r64[31:0], q64[31:0]};
   endfunction

   task automatic push(input int c, input logic [63:0] h, input bit d, input bit z);
      exp_t e;
      e.cyc = c; e.hilo = h; e.is_div = d; e.dbz = z;
      q.push_back(e);
   endtask

   // Called #1 after a rising edge; inputs are sampled at the next edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] alu);
      bit idle;
      Valid = 1'b1; Op = op; A = a; B = b; ALU64Result = alu;
      idle = !(cyc >= bf && cyc <= bt);
      if (idle) begin
         case (op)
            3'd1: begin dm = alu; push(cyc + 1, dm, 0, 0); end
            3'd2: begin dm[63:32] = a; push(cyc + 1, dm, 0, 0); end
            3'd3: begin dm[31:0] = a; push(cyc + 1, dm, 0, 0); end
            3'd4, 3'd5: begin
               dm = ref_div(op, a, b);
               bf = cyc + 1;
               if (b == 0) begin
                  bt = cyc + 1;
                  push(cyc + 2, dm, 1, 1);
               end else begin
                  bt = cyc + 33;
                  push(cyc + 34, dm, 1, 0);
               end
            end
            default: ;
         endcase
      end
      @(posedge Clk); #1;
      Valid = 1'b0; Op = 3'd0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   always @(negedge Clk) begin : monitor
      exp_t e;
      bit   m;
      if (!Reset) begin
         m = (q.size() > 0) && (q[0].cyc == cyc);
         if (m) e = q[0];
         chk("done", 64'(Done), 64'(m && e.is_div));
         chk("divbyzero", 64'(DivByZero), 64'(m && e.dbz));
         chk("busy", 64'(Busy), 64'(cyc >= bf && cyc <= bt));
         if (m) begin
            void'(q.pop_front());
            mon = e.hilo;
         end
         chk("hilo", HiLo, mon);
      end
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      wait_cycles(3);
      chk("reset_hilo", HiLo, 64'd0);
      chk("reset_busy", 64'(Busy), 64'd0);
      chk("reset_done", 64'(Done), 64'd0);
      chk("reset_dbz", 64'(DivByZero), 64'd0);
      Reset = 1'b0;
      wait_cycles(2);

      issue(3'd1, 32'd0, 32'd0, 64'h0000_0001_FFFF_FFFE);
      issue(3'd3, 32'h1234, 32'd0, 64'd0);
      wait_cycles(1);
      chk("mtlo_value", HiLo, 64'h0000_0001_0000_1234);
      issue(3'd2, 32'hCAFE_F00D, 32'd0, 64'd0);

      issue(3'd5, 32'd100, 32'd7, 64'd0);
      wait_cycles(34);
      chk("divu_100_7", HiLo, {32'd2, 32'd14});
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 64'd0);
      wait_cycles(34);
      chk("div_m7_2", HiLo, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
      wait_cycles(34);
      chk("div_min_m1", HiLo, {32'd0, 32'h8000_0000});
      issue(3'd5, 32'd55, 32'd0, 64'd0);
      wait_cycles(2);
      chk("divu_by_zero", HiLo, {32'd55, 32'hFFFF_FFFF});

      // WR64 mid-divide is ignored; WR64 in the Done cycle is accepted.
      issue(3'd5, 32'd1000, 32'd3, 64'd0);
      wait_cycles(4);
      issue(3'd1, 32'd0, 32'd0, 64'hDEAD_BEEF_0BAD_F00D);
      while (cyc < bt + 1) wait_cycles(1);
      issue(3'd1, 32'd0, 32'd0, 64'h1111_2222_3333_4444);
      wait_cycles(1);

      // Asynchronous reset at cycle 10 of a divide.
      issue(3'd4, 32'hFFF0_0000, 32'd9, 64'd0);
      wait_cycles(9);
      Reset = 1'b1;
      #1;
      chk("async_rst_hilo", HiLo, 64'd0);
      chk("async_rst_busy", 64'(Busy), 64'd0);
      q.delete(); dm = '0; mon = '0; bf = 1; bt = 0;
      wait_cycles(2);
      Reset = 1'b0;
      wait_cycles(40);

      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         issue(op, a, b, {$urandom, $urandom});
         wait_cycles($urandom_range(0, 3));
      end

      wait_cycles(40);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
